// File: rtl/gb_pkg.sv
// Shared definitions for the CB-prefix execution path: FSM states,
// opcode class codes, register indices and flag bit positions.
package gb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    localparam logic [1:0] CLS_SHIFT = 2'b00;
    localparam logic [1:0] CLS_BIT   = 2'b01;
    localparam logic [1:0] CLS_RES   = 2'b10;
    localparam logic [1:0] CLS_SET   = 2'b11;

    localparam logic [2:0] REG_B = 3'd0;
    localparam logic [2:0] REG_C = 3'd1;
    localparam logic [2:0] REG_D = 3'd2;
    localparam logic [2:0] REG_E = 3'd3;
    localparam logic [2:0] REG_H = 3'd4;
    localparam logic [2:0] REG_L = 3'd5;
    localparam logic [2:0] REG_A = 3'd7;

    localparam logic [2:0] HL_TARGET = 3'd6;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_H = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/bit_ops.sv
// Combinational CB-page bit-operation unit. RES/SET report Z of the
// result with H=0; carry passes through for BIT, RES and SET.
module bit_ops
    import gb_pkg::*;
(
    input  logic [4:0] sel_i,
    input  logic [7:0] operand_i,
    input  logic       carry_i,
    output logic [7:0] result_o,
    output logic       z_o,
    output logic       h_o,
    output logic       c_o
);

    logic [1:0] cls;
    logic [2:0] idx;
    logic [7:0] mask;
    logic [7:0] v;

    assign cls  = sel_i[4:3];
    assign idx  = sel_i[2:0];
    assign mask = 8'd1 << idx;
    assign v    = operand_i;

    always_comb begin
        result_o = v;
        h_o      = 1'b0;
        c_o      = carry_i;
        unique case (cls)
            CLS_SHIFT: begin
                unique case (idx)
                    3'd0: {c_o, result_o} = {v[7], v[6:0], v[7]};
                    3'd1: {c_o, result_o} = {v[0], v[0], v[7:1]};
                    3'd2: {c_o, result_o} = {v[7], v[6:0], carry_i};
                    3'd3: {c_o, result_o} = {v[0], carry_i, v[7:1]};
                    3'd4: {c_o, result_o} = {v[7], v[6:0], 1'b0};
                    3'd5: {c_o, result_o} = {v[0], v[7], v[7:1]};
                    3'd6: {c_o, result_o} = {1'b0, v[3:0], v[7:4]};
                    3'd7: {c_o, result_o} = {v[0], 1'b0, v[7:1]};
                    default: result_o = v;
                endcase
            end
            CLS_BIT: h_o = 1'b1;
            CLS_RES: result_o = v & ~mask;
            CLS_SET: result_o = v | mask;
            default: result_o = v;
        endcase
        z_o = (cls == CLS_BIT) ? ~|(v & mask) : ~|result_o;
    end

endmodule

// File: rtl/cb_exec.sv
// CB-prefix execution sequencer. Define CB_HL_TARGET_EN to build the
// (HL) memory read/write path; otherwise target 6 reports illegal.
module cb_exec
    import gb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  opcode,
    input  logic [15:0] hl,
    input  logic [3:0]  flags_in,
    output logic [2:0]  reg_sel,
    input  logic [7:0]  reg_rdata,
    output logic        reg_we,
    output logic [7:0]  reg_wdata,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready,
    output logic        flags_we,
    output logic [3:0]  flags_out,
    output logic        busy,
    output logic        done,
    output logic        illegal
);

    state_e     state_q;
    logic [7:0] op_q;

`ifdef CB_HL_TARGET_EN
    logic [15:0] hl_q;
    logic [7:0]  opnd_q;
    logic [7:0]  res_q;
`endif

    logic [7:0] operand;
    logic [7:0] unit_res;
    logic       unit_z;
    logic       unit_h;
    logic       unit_c;
    logic       is_hl;
    logic       is_bit;
    logic       exec;
    logic [3:0] flags_new;
    logic       unused;

    assign is_hl  = op_q[2:0] == HL_TARGET;
    assign is_bit = op_q[7:6] == CLS_BIT;
    assign exec   = state_q == ST_EXEC;

`ifdef CB_HL_TARGET_EN
    assign operand = is_hl ? opnd_q : reg_rdata;
    assign unused  = ^flags_in[3:1];
`else
    assign operand = reg_rdata;
    assign unused  = ^{flags_in[3:1], hl, mem_rdata, mem_ready};
`endif

    bit_ops u_bit_ops (
        .sel_i     (op_q[7:3]),
        .operand_i (operand),
        .carry_i   (flags_in[FLAG_C]),
        .result_o  (unit_res),
        .z_o       (unit_z),
        .h_o       (unit_h),
        .c_o       (unit_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
`ifdef CB_HL_TARGET_EN
            hl_q    <= '0;
            opnd_q  <= '0;
            res_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        op_q <= opcode;
`ifdef CB_HL_TARGET_EN
                        hl_q    <= hl;
                        state_q <= (opcode[2:0] == HL_TARGET)
                                   ? ST_READ : ST_EXEC;
`else
                        state_q <= ST_EXEC;
`endif
                    end
                end
`ifdef CB_HL_TARGET_EN
                ST_READ: begin
                    if (mem_ready) begin
                        opnd_q  <= mem_rdata;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_hl && !is_bit) begin
                        res_q   <= unit_res;
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    if (mem_ready) state_q <= ST_IDLE;
                end
`else
                ST_EXEC: state_q <= ST_IDLE;
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        flags_new         = '0;
        flags_new[FLAG_Z] = unit_z;
        flags_new[FLAG_H] = unit_h;
        flags_new[FLAG_C] = unit_c;
    end

    // Data outputs read as zero unless their strobe is active.
    assign busy      = state_q != ST_IDLE;
    assign reg_sel   = busy ? op_q[2:0] : 3'd0;
    assign reg_we    = exec && !is_hl && !is_bit;
    assign reg_wdata = reg_we ? unit_res : 8'd0;
    assign flags_out = flags_we ? flags_new : 4'd0;

`ifdef CB_HL_TARGET_EN
    assign illegal   = 1'b0;
    assign flags_we  = exec;
    assign mem_rd    = state_q == ST_READ;
    assign mem_wr    = state_q == ST_WRITE;
    assign mem_addr  = (mem_rd || mem_wr) ? hl_q : 16'd0;
    assign mem_wdata = mem_wr ? res_q : 8'd0;
    assign done      = (exec && (!is_hl || is_bit))
                     || (mem_wr && mem_ready);
`else
    assign illegal   = exec && is_hl;
    assign flags_we  = exec && !is_hl;
    assign mem_rd    = 1'b0;
    assign mem_wr    = 1'b0;
    assign mem_addr  = 16'd0;
    assign mem_wdata = 8'd0;
    assign done      = exec;
`endif

endmodule

// File: tb/tb_cb_exec.sv
// Randomized bench for cb_exec against a cycle-schedule and
// arithmetic reference model of the CB-page operations.
module tb_cb_exec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  opcode = 8'd0;
    logic [15:0] hl = 16'd0;
    logic [3:0]  flags_in = 4'd0;
    logic [2:0]  reg_sel;
    logic [7:0]  reg_rdata;
    logic        reg_we;
    logic [7:0]  reg_wdata;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready = 1'b0;
    logic        flags_we;
    logic [3:0]  flags_out;
    logic        busy;
    logic        done;
    logic        illegal;

    logic [7:0] regs [8];
    logic [7:0] mem [256];
    int checks = 0;
    int errors = 0;

`ifdef CB_HL_TARGET_EN
    localparam bit HL_EN = 1'b1;
`else
    localparam bit HL_EN = 1'b0;
`endif

    assign reg_rdata = regs[reg_sel];
    assign mem_rdata = mem[mem_addr[7:0]];

    always #5 clk = ~clk;

    cb_exec dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .opcode    (opcode),
        .hl        (hl),
        .flags_in  (flags_in),
        .reg_sel   (reg_sel),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .flags_we  (flags_we),
        .flags_out (flags_out),
        .busy      (busy),
        .done      (done),
        .illegal   (illegal)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sel"}, 32'(reg_sel), 0);
        chk({tag, "_we"}, 32'(reg_we), 0);
        chk({tag, "_wdata"}, 32'(reg_wdata), 0);
        chk({tag, "_addr"}, 32'(mem_addr), 0);
        chk({tag, "_rd"}, 32'(mem_rd), 0);
        chk({tag, "_wr"}, 32'(mem_wr), 0);
        chk({tag, "_mwdata"}, 32'(mem_wdata), 0);
        chk({tag, "_fwe"}, 32'(flags_we), 0);
        chk({tag, "_fout"}, 32'(flags_out), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_ill"}, 32'(illegal), 0);
    endtask

    // Returns {result, Z, N, H, C} using integer arithmetic on the byte.
    function automatic logic [11:0] ref_op(input logic [7:0] op,
                                           input logic [7:0] v8,
                                           input logic cin);
        int v;
        int idx;
        int r;
        int co;
        int b;
        logic z;
        logic h;
        v   = {24'd0, v8};
        idx = {29'd0, op[5:3]};
        co  = {31'd0, cin};
        h   = 1'b0;
        b   = (v >> idx) % 2;
        r   = v;
        case (op[7:6])
            2'd0: begin
                case (idx)
                    0: begin r = (v * 2) % 256 + v / 128; co = v / 128; end
                    1: begin r = v / 2 + (v % 2) * 128; co = v % 2; end
                    2: begin r = (v * 2) % 256 + co; co = v / 128; end
                    3: begin r = v / 2 + co * 128; co = v % 2; end
                    4: begin r = (v * 2) % 256; co = v / 128; end
                    5: begin r = v / 2 + (v / 128) * 128; co = v % 2; end
                    6: begin r = (v % 16) * 16 + v / 16; co = 0; end
                    default: begin r = v / 2; co = v % 2; end
                endcase
            end
            2'd1: h = 1'b1;
            2'd2: r = v - b * (1 << idx);
            default: r = v + (1 - b) * (1 << idx);
        endcase
        z = (op[7:6] == 2'd1) ? (b == 0) : (r == 0);
        return {r[7:0], z, 1'b0, h, co[0]};
    endfunction

    task automatic run_op(input logic [7:0] op, input logic [15:0] hv,
                          input logic [3:0] fv, input int sr,
                          input int sw, input int abort_c);
        logic [2:0] tgt;
        logic [1:0] cls;
        bit hl_t;
        bit hl_run;
        logic [7:0] opnd;
        logic [7:0] er;
        logic [3:0] ef;
        int rd_last;
        int exec_c;
        int wr_first;
        int wr_last;
        int done_c;
        tgt    = op[2:0];
        cls    = op[7:6];
        hl_t   = tgt == 3'd6;
        hl_run = hl_t && HL_EN;
        opnd   = hl_t ? mem[hv[7:0]] : regs[tgt];
        {er, ef} = ref_op(op, opnd, fv[0]);
        rd_last  = 0;
        wr_first = 0;
        wr_last  = 0;
        if (hl_run) begin
            rd_last = 1 + sr;
            exec_c  = rd_last + 1;
            done_c  = exec_c;
            if (cls != 2'd1) begin
                wr_first = exec_c + 1;
                wr_last  = wr_first + sw;
                done_c   = wr_last;
            end
        end else begin
            exec_c = 1;
            done_c = 1;
        end

        @(negedge clk);
        #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_sel", 32'(reg_sel), 0);
        start     = 1'b1;
        opcode    = op;
        hl        = hv;
        flags_in  = fv;
        mem_ready = 1'($urandom_range(0, 1));

        for (int c = 1; c <= done_c; c++) begin
            bit in_rd;
            bit in_wr;
            bit fwe;
            bit rwe;
            @(negedge clk);
            in_rd  = hl_run && c <= rd_last;
            in_wr  = wr_first != 0 && c >= wr_first && c <= wr_last;
            start  = (c < done_c) ? 1'($urandom_range(0, 1)) : 1'b0;
            opcode = 8'($urandom_range(0, 255));
            hl     = 16'($urandom_range(0, 65535));
            if (in_rd)
                mem_ready = (c == rd_last);
            else if (in_wr)
                mem_ready = (c == wr_last);
            else
                mem_ready = 1'($urandom_range(0, 1));
            #1;
            fwe = c == exec_c && !(hl_t && !HL_EN);
            rwe = c == exec_c && !hl_t && cls != 2'd1;
            chk("busy", 32'(busy), 1);
            chk("done", 32'(done), 32'(c == done_c));
            chk("illegal", 32'(illegal),
                32'(c == done_c && hl_t && !HL_EN));
            chk("reg_sel", 32'(reg_sel), 32'(tgt));
            chk("reg_we", 32'(reg_we), 32'(rwe));
            if (rwe) chk("reg_wdata", 32'(reg_wdata), 32'(er));
            chk("flags_we", 32'(flags_we), 32'(fwe));
            if (fwe) chk("flags_out", 32'(flags_out), 32'(ef));
            chk("mem_rd", 32'(mem_rd), 32'(in_rd));
            chk("mem_wr", 32'(mem_wr), 32'(in_wr));
            chk("mem_addr", 32'(mem_addr),
                (in_rd || in_wr) ? 32'(hv) : 0);
            chk("mem_wdata", 32'(mem_wdata), in_wr ? 32'(er) : 0);
            if (c == abort_c) begin
                start = 1'b0;
                rst   = 1'b1;
                #1;
                chk_reset("abort");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        start = 1'b0;
        if (!hl_t && cls != 2'd1) regs[tgt] = er;
        if (hl_run && cls != 2'd1) mem[hv[7:0]] = er;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) regs[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
        #12;
        chk_reset("rst");
        @(negedge clk);
        rst = 1'b0;

        regs[0] = 8'h85;
        run_op(8'h00, 16'h0000, 4'h0, 0, 0, 0);
        regs[7] = 8'h00;
        run_op(8'h37, 16'h0000, 4'h0, 0, 0, 0);
        mem[8'h00] = 8'h0F;
        run_op(8'hFE, 16'hC000, 4'h0, 0, 0, 0);
        run_op(8'h46, 16'hC000, 4'h1, 0, 0, 0);
        run_op(8'h86, 16'hC000, 4'h0, 3, 0, 0);
`ifdef CB_HL_TARGET_EN
        run_op(8'hFE, 16'hC010, 4'h0, 0, 4, 3);
`else
        run_op(8'h00, 16'hC010, 4'h0, 0, 0, 1);
`endif
        run_op(8'hC7, 16'h1234, 4'h2, 1, 1, 0);

        for (int n = 0; n < 60; n++) begin
            logic [7:0] op;
            op = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 2) == 0) op[2:0] = 3'd6;
            run_op(op, 16'($urandom_range(0, 65535)),
                   4'($urandom_range(0, 15)),
                   $urandom_range(0, 3), $urandom_range(0, 3), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
